// File: rtl/nts_tx_streamer_pkg.sv
// Shared definitions for the NTS transmit streamer: FSM encoding, MAC word width
// and the byte-count to lane-mask conversion.
package nts_tx_streamer_pkg;

    localparam int NTS_MAC_DATA_WIDTH = 64;
    localparam int NTS_MASK_WIDTH     = NTS_MAC_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH0 = 3'd1,
        FETCH1 = 3'd2,
        START  = 3'd3,
        STREAM = 3'd4,
        DONE   = 3'd5,
        GAP    = 3'd6
    } tx_state_t;

    // A count of 0 means a full final word, as do out-of-range counts.
    function automatic logic [7:0] bytes_to_mask(input logic [3:0] n);
        logic [7:0] m;
        if (n == 4'd0 || n >= 4'd8) begin
            m = 8'hFF;
        end else begin
            m = 8'((9'd1 << n) - 9'd1);
        end
        return m;
    endfunction

endpackage

// File: rtl/nts_tx_mask_gen.sv
// Combinational final-word byte-lane mask from the engine's valid-byte count.
module nts_tx_mask_gen
    import nts_tx_streamer_pkg::*;
(
    input  logic [3:0] byte_count,
    output logic [7:0] mask
);

    assign mask = bytes_to_mask(byte_count);

endmodule

// File: rtl/nts_tx_streamer.sv
// Moves one complete packet at a time from the engine TX FIFO to the MAC TX port,
// with a start/ack handshake, bubble-free streaming, underrun abort and inter-frame gap.
module nts_tx_streamer
    import nts_tx_streamer_pkg::*;
#(
    parameter int MAC_DATA_WIDTH = NTS_MAC_DATA_WIDTH,
    parameter int IFG_CYCLES     = 4
) (
    input  logic                        i_clk,
    input  logic                        i_areset,
    input  logic                        i_engine_packet_available,
    output logic                        o_engine_packet_read,
    input  logic                        i_engine_fifo_empty,
    output logic                        o_engine_fifo_rd_en,
    input  logic [MAC_DATA_WIDTH-1:0]   i_engine_fifo_rd_data,
    input  logic [3:0]                  i_engine_bytes_last_word,
    output logic                        o_mac_tx_start,
    input  logic                        i_mac_tx_ack,
    output logic [MAC_DATA_WIDTH/8-1:0] o_mac_tx_data_valid,
    output logic [MAC_DATA_WIDTH-1:0]   o_mac_tx_data,
    output logic                        o_mac_tx_underrun,
    output logic [31:0]                 o_frames_sent,
    output logic [15:0]                 o_underruns,
    output logic [2:0]                  dbg_state
);

    localparam int MASK_W = MAC_DATA_WIDTH / 8;

    tx_state_t                 state;
    logic [MAC_DATA_WIDTH-1:0] stage_data;
    logic                      stage_full;
    logic                      stage_last;
    logic                      out_last;
    logic                      pend;
    logic [3:0]                gap_cnt;
    logic [MASK_W-1:0]         last_mask;

    logic                      rd_en;
    logic                      nxt_avail;
    logic                      nxt_last;
    logic [MAC_DATA_WIDTH-1:0] nxt_data;
    logic                      load_now;
    logic                      finish_now;
    logic                      abort_now;

    nts_tx_mask_gen u_mask_gen (
        .byte_count (i_engine_bytes_last_word),
        .mask       (last_mask)
    );

    // The next word comes straight off the FIFO when a read returns this cycle,
    // otherwise from the stage register filled while START waited for ack.
    always_comb begin
        nxt_avail  = pend | stage_full;
        nxt_data   = pend ? i_engine_fifo_rd_data : stage_data;
        nxt_last   = pend ? i_engine_fifo_empty : stage_last;
        rd_en      = 1'b0;
        load_now   = 1'b0;
        finish_now = 1'b0;
        abort_now  = 1'b0;
        case (state)
            FETCH0: rd_en = ~i_engine_fifo_empty;
            FETCH1: rd_en = ~i_engine_fifo_empty;
            START: begin
                rd_en      = i_mac_tx_ack & ~out_last & nxt_avail & ~nxt_last & ~i_engine_fifo_empty;
                finish_now = i_mac_tx_ack & out_last;
                load_now   = i_mac_tx_ack & ~out_last & nxt_avail;
                abort_now  = i_mac_tx_ack & ~out_last & ~nxt_avail;
            end
            STREAM: begin
                rd_en      = ~out_last & pend & ~i_engine_fifo_empty;
                finish_now = out_last;
                load_now   = ~out_last & pend;
                abort_now  = ~out_last & ~pend;
            end
            default: rd_en = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state                <= IDLE;
            stage_data           <= '0;
            stage_full           <= 1'b0;
            stage_last           <= 1'b0;
            out_last             <= 1'b0;
            pend                 <= 1'b0;
            gap_cnt              <= '0;
            o_engine_packet_read <= 1'b0;
            o_mac_tx_start       <= 1'b0;
            o_mac_tx_data_valid  <= '0;
            o_mac_tx_data        <= '0;
            o_mac_tx_underrun    <= 1'b0;
            o_frames_sent        <= '0;
            o_underruns          <= '0;
        end else begin
            pend                 <= rd_en;
            o_engine_packet_read <= 1'b0;
            o_mac_tx_underrun    <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_engine_packet_available && !i_engine_fifo_empty) state <= FETCH0;
                end
                FETCH0: begin
                    if (rd_en) state <= FETCH1;
                end
                FETCH1: begin
                    o_mac_tx_data       <= i_engine_fifo_rd_data;
                    out_last            <= i_engine_fifo_empty;
                    o_mac_tx_data_valid <= i_engine_fifo_empty ? last_mask : '1;
                    o_mac_tx_start      <= 1'b1;
                    stage_full          <= 1'b0;
                    state               <= START;
                end
                START: begin
                    if (pend) begin
                        stage_data <= i_engine_fifo_rd_data;
                        stage_last <= i_engine_fifo_empty;
                        stage_full <= 1'b1;
                    end
                    if (i_mac_tx_ack) begin
                        o_mac_tx_start <= 1'b0;
                        stage_full     <= 1'b0;
                    end
                end
                DONE: begin
                    gap_cnt <= 4'(IFG_CYCLES - 1);
                    state   <= GAP;
                end
                GAP: begin
                    if (gap_cnt == 4'd0) state <= IDLE;
                    else gap_cnt <= gap_cnt - 4'd1;
                end
                default: state <= state;
            endcase

            if (load_now) begin
                o_mac_tx_data       <= nxt_data;
                out_last            <= nxt_last;
                o_mac_tx_data_valid <= nxt_last ? last_mask : '1;
                state               <= STREAM;
            end
            if (finish_now) begin
                o_mac_tx_data_valid  <= '0;
                o_engine_packet_read <= 1'b1;
                if (o_frames_sent != '1) o_frames_sent <= o_frames_sent + 32'd1;
                state                <= DONE;
            end
            // A word was due but its read was held off by an empty FIFO that never marked a last word.
            if (abort_now) begin
                o_mac_tx_data_valid  <= '0;
                o_mac_tx_underrun    <= 1'b1;
                o_engine_packet_read <= 1'b1;
                if (o_underruns != '1) o_underruns <= o_underruns + 16'd1;
                gap_cnt              <= 4'(IFG_CYCLES - 1);
                state                <= GAP;
            end
        end
    end

    assign o_engine_fifo_rd_en = rd_en;
    assign dbg_state           = state;

endmodule

// File: tb/tb_nts_tx_streamer.sv
// Bench for nts_tx_streamer: engine FIFO model, directed and random packets,
// expected frames built from packet contents and byte counts.
module tb_nts_tx_streamer;
    import nts_tx_streamer_pkg::*;

    localparam int IFG = 4;

    logic        clk = 1'b0;
    logic        areset;
    logic        engine_packet_available;
    logic        engine_packet_read;
    logic        engine_fifo_empty;
    logic        engine_fifo_rd_en;
    logic [63:0] engine_fifo_rd_data;
    logic [3:0]  engine_bytes_last_word;
    logic        mac_tx_start;
    logic        mac_tx_ack;
    logic [7:0]  mac_tx_data_valid;
    logic [63:0] mac_tx_data;
    logic        mac_tx_underrun;
    logic [31:0] frames_sent;
    logic [15:0] underruns;
    logic [2:0]  dbg_state;

    logic [63:0] fifo_q[$];
    logic        fifo_empty_r;
    logic        force_empty;
    int          checks = 0;
    int          errors = 0;
    int          pr_count = 0;
    int          idle_run = 0;
    int          exp_frames = 0;
    int          exp_unders = 0;

    always #5 clk = ~clk;

    nts_tx_streamer #(.MAC_DATA_WIDTH(64), .IFG_CYCLES(IFG)) dut (
        .i_clk                     (clk),
        .i_areset                  (areset),
        .i_engine_packet_available (engine_packet_available),
        .o_engine_packet_read      (engine_packet_read),
        .i_engine_fifo_empty       (engine_fifo_empty),
        .o_engine_fifo_rd_en       (engine_fifo_rd_en),
        .i_engine_fifo_rd_data     (engine_fifo_rd_data),
        .i_engine_bytes_last_word  (engine_bytes_last_word),
        .o_mac_tx_start            (mac_tx_start),
        .i_mac_tx_ack              (mac_tx_ack),
        .o_mac_tx_data_valid       (mac_tx_data_valid),
        .o_mac_tx_data             (mac_tx_data),
        .o_mac_tx_underrun         (mac_tx_underrun),
        .o_frames_sent             (frames_sent),
        .o_underruns               (underruns),
        .dbg_state                 (dbg_state)
    );

    assign engine_fifo_empty = fifo_empty_r | force_empty;

    // Engine FIFO: pop returns data next cycle, empty flag registered alongside it.
    // The engine drops any leftover words of a packet once it is marked read.
    always @(posedge clk or posedge areset) begin
        if (areset) begin
            fifo_q.delete();
            fifo_empty_r            <= 1'b1;
            engine_fifo_rd_data     <= '0;
            engine_packet_available <= 1'b0;
        end else begin
            if (engine_fifo_rd_en) begin
                checks++;
                assert (!engine_fifo_empty && fifo_q.size() > 0) else begin
                    errors++;
                    $error("FAIL rd_when_empty got rd_en=1 empty=%b level=%0d exp no read", engine_fifo_empty, fifo_q.size());
                end
                if (fifo_q.size() > 0) engine_fifo_rd_data <= fifo_q.pop_front();
            end
            if (engine_packet_read) begin
                fifo_q.delete();
                engine_packet_available <= 1'b0;
            end
            fifo_empty_r <= (fifo_q.size() == 0);
        end
    end

    always @(posedge clk) begin
        if (engine_packet_read) pr_count++;
        if (mac_tx_data_valid == 8'h00) idle_run++;
        else idle_run = 0;
    end

    task automatic send_packet(input int nw, input int blw, input int ack_dly,
                               input bit do_underrun, input bit check_gap, input bit stray_ack);
        logic [63:0] words[$];
        logic [7:0]  last_mask;
        int          nbytes;
        int          cyc;
        int          start_cycles;
        int          n_shown;
        logic [7:0]  exp_mask;
        nbytes    = (blw == 0) ? 8 : blw;
        last_mask = 8'h00;
        for (int b = 0; b < 8; b++) if (b < nbytes) last_mask[b] = 1'b1;
        for (int i = 0; i < nw; i++) words.push_back({$urandom, $urandom});
        engine_bytes_last_word = 4'(blw);
        foreach (words[i]) fifo_q.push_back(words[i]);
        engine_packet_available = 1'b1;

        cyc = 0;
        while (mac_tx_start !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        assert (mac_tx_start === 1'b1) else begin
            errors++;
            $error("FAIL start_timeout got=%b exp=1", mac_tx_start);
        end
        if (mac_tx_start !== 1'b1) return;
        if (check_gap) begin
            checks++;
            assert (idle_run >= IFG) else begin
                errors++;
                $error("FAIL ifg got=%0d exp>=%0d", idle_run, IFG);
            end
        end

        exp_mask     = (nw == 1) ? last_mask : 8'hFF;
        start_cycles = 0;
        while (mac_tx_start === 1'b1 && start_cycles < ack_dly) begin
            start_cycles++;
            checks++;
            assert (mac_tx_data === words[0] && mac_tx_data_valid === exp_mask) else begin
                errors++;
                $error("FAIL word0 got=%h/%h exp=%h/%h", mac_tx_data, mac_tx_data_valid, words[0], exp_mask);
            end
            if (start_cycles == ack_dly) begin
                mac_tx_ack = 1'b1;
                if (do_underrun) force_empty = 1'b1;
            end
            @(negedge clk);
        end
        mac_tx_ack  = stray_ack;
        force_empty = 1'b0;
        checks++;
        assert (start_cycles == ack_dly && mac_tx_start === 1'b0) else begin
            errors++;
            $error("FAIL start_hold got=%0d/%b exp=%0d/0", start_cycles, mac_tx_start, ack_dly);
        end

        n_shown = do_underrun ? 2 : nw;
        for (int i = 1; i < n_shown; i++) begin
            exp_mask = (i == nw - 1) ? last_mask : 8'hFF;
            checks++;
            assert (mac_tx_data === words[i] && mac_tx_data_valid === exp_mask) else begin
                errors++;
                $error("FAIL word%0d got=%h/%h exp=%h/%h", i, mac_tx_data, mac_tx_data_valid, words[i], exp_mask);
            end
            @(negedge clk);
            mac_tx_ack = 1'b0;
        end

        checks++;
        assert (mac_tx_data_valid === 8'h00 && engine_packet_read === 1'b1 && mac_tx_underrun === do_underrun) else begin
            errors++;
            $error("FAIL frame_end got=v%h pr%b ur%b exp=v00 pr1 ur%b", mac_tx_data_valid, engine_packet_read, mac_tx_underrun, do_underrun);
        end
        if (do_underrun) exp_unders++;
        else exp_frames++;
        mac_tx_ack = 1'b0;
        @(negedge clk);
        checks++;
        assert (frames_sent === 32'(exp_frames) && underruns === 16'(exp_unders) &&
                engine_packet_read === 1'b0 && mac_tx_underrun === 1'b0) else begin
            errors++;
            $error("FAIL counters got=%0d/%0d pr%b ur%b exp=%0d/%0d pr0 ur0", frames_sent, underruns,
                   engine_packet_read, mac_tx_underrun, exp_frames, exp_unders);
        end
    endtask

    initial begin
        logic [63:0] rw[$];
        int          cyc;
        int          pr_before;
        areset                 = 1'b1;
        mac_tx_ack             = 1'b0;
        force_empty            = 1'b0;
        engine_bytes_last_word = 4'd0;
        repeat (3) @(negedge clk);
        checks++;
        assert ({mac_tx_start, mac_tx_data_valid, mac_tx_data, engine_packet_read, mac_tx_underrun,
                 engine_fifo_rd_en, frames_sent, underruns} === '0 && dbg_state === 3'(IDLE)) else begin
            errors++;
            $error("FAIL reset_state got=s%b v%h d%h fs%0d ur%0d st%0d exp all zero", mac_tx_start,
                   mac_tx_data_valid, mac_tx_data, frames_sent, underruns, dbg_state);
        end
        areset = 1'b0;
        repeat (2) @(negedge clk);

        send_packet(1, 5, 3, 1'b0, 1'b0, 1'b0);
        send_packet(10, 8, 1, 1'b0, 1'b1, 1'b0);
        send_packet(3, 2, 1, 1'b0, 1'b1, 1'b1);
        send_packet(2, 0, 2, 1'b0, 1'b1, 1'b0);
        send_packet(1, 0, 1, 1'b0, 1'b1, 1'b1);
        send_packet(5, 4, 3, 1'b1, 1'b1, 1'b0);
        send_packet(4, 7, 1, 1'b0, 1'b1, 1'b0);
        repeat (8) begin
            send_packet($urandom_range(1, 12), $urandom_range(0, 8), $urandom_range(1, 4),
                        1'b0, 1'b1, 1'($urandom_range(0, 1)));
        end

        // Abort a frame while its fifth word is on the bus.
        for (int i = 0; i < 8; i++) rw.push_back({$urandom, $urandom});
        engine_bytes_last_word = 4'd8;
        foreach (rw[i]) fifo_q.push_back(rw[i]);
        engine_packet_available = 1'b1;
        cyc = 0;
        while (mac_tx_start !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        mac_tx_ack = 1'b1;
        @(negedge clk);
        mac_tx_ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        assert (mac_tx_data === rw[4] && mac_tx_data_valid === 8'hFF) else begin
            errors++;
            $error("FAIL pre_reset_word4 got=%h/%h exp=%h/ff", mac_tx_data, mac_tx_data_valid, rw[4]);
        end
        pr_before = pr_count;
        areset    = 1'b1;
        #1;
        checks++;
        assert ({mac_tx_start, mac_tx_data_valid, mac_tx_data, engine_packet_read, mac_tx_underrun,
                 engine_fifo_rd_en, frames_sent, underruns} === '0) else begin
            errors++;
            $error("FAIL midframe_reset got=v%h d%h pr%b fs%0d ur%0d exp all zero", mac_tx_data_valid,
                   mac_tx_data, engine_packet_read, frames_sent, underruns);
        end
        exp_frames = 0;
        exp_unders = 0;
        @(negedge clk);
        areset = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        assert (pr_count == pr_before && mac_tx_data_valid === 8'h00) else begin
            errors++;
            $error("FAIL reset_no_read got=%0d pulses exp=%0d", pr_count, pr_before);
        end

        send_packet(3, 6, 2, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
